// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register that feeds the 32-bit ALU. It captures the decoded
// instruction and picks the A/B operands (register value, immediate or shift
// amount). Operands are forwarded from EX/MEM and MEM/WB. It also detects
// load-use hazards and inserts one bubble for each one.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 pipeline-wide freeze: hold the stage contents
//   flush                 squash: capture a bubble on the next edge
//   id_*                  decoded instruction from the ID stage
//   exmem_*, memwb_*      forwarding sources (destination index, data, enable)
//   ex_*                  registered control/index outputs to EX
//   ex_a, ex_b            ALU operands (combinational, forwarded)
//   ex_store_data         forwarded rt value for stores
//   load_use_hazard       combinational; upstream holds PC and IF/ID while high
//
// Flow control: there is no valid/ready pair. `stall` is a global hold that
// freezes this register. `load_use_hazard` is the stage's backpressure to
// upstream: while it is high, the ID instruction is not accepted (a bubble is
// captured instead), and upstream must present the same instruction again on
// the next cycle.
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [3:0]          id_alu_operation,
  input  logic                id_alu_src,
  input  logic                id_shift,
  input  logic [WIDTH-1:0]    id_read_data1,
  input  logic [WIDTH-1:0]    id_read_data2,
  input  logic [WIDTH-1:0]    id_immediate,
  input  logic [4:0]          id_shamt,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_write_reg,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                exmem_reg_write,
  input  logic [REG_BITS-1:0] exmem_write_reg,
  input  logic [WIDTH-1:0]    exmem_alu_result,
  input  logic                memwb_reg_write,
  input  logic [REG_BITS-1:0] memwb_write_reg,
  input  logic [WIDTH-1:0]    memwb_write_data,
  output logic                ex_valid,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic [3:0]          ex_alu_operation,
  output logic [REG_BITS-1:0] ex_write_reg,
  output logic [WIDTH-1:0]    ex_a,
  output logic [WIDTH-1:0]    ex_b,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic                load_use_hazard
);

  // An all-zero value is a bubble: invalid, no control, ALU op AND, data 0.
  typedef struct packed {
    logic                valid;
    logic [3:0]          alu_op;
    logic                alu_src;
    logic                shift;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic [WIDTH-1:0]    imm;
    logic [4:0]          shamt;
    logic [REG_BITS-1:0] rs;
    logic [REG_BITS-1:0] rt;
    logic [REG_BITS-1:0] write_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
  } stage_t;

  stage_t           stage_q;
  stage_t           stage_d;
  stage_t           id_stage;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  always_comb begin
    id_stage            = '0;
    id_stage.valid      = id_valid;
    id_stage.alu_op     = id_alu_operation;
    id_stage.alu_src    = id_alu_src;
    id_stage.shift      = id_shift;
    id_stage.rd1        = id_read_data1;
    id_stage.rd2        = id_read_data2;
    id_stage.imm        = id_immediate;
    id_stage.shamt      = id_shamt;
    id_stage.rs         = id_rs;
    id_stage.rt         = id_rt;
    id_stage.write_reg  = id_write_reg;
    id_stage.reg_write  = id_reg_write;
    id_stage.mem_read   = id_mem_read;
    id_stage.mem_write  = id_mem_write;
    id_stage.mem_to_reg = id_mem_to_reg;
  end

  // A load in EX whose destination is read by the ID instruction. rt is
  // compared even when the ID instruction uses an immediate. This is
  // conservative: it can cost an extra bubble, but it is never wrong.
  assign load_use_hazard = stage_q.valid & stage_q.mem_read &
                           (stage_q.write_reg != '0) & id_valid &
                           ((stage_q.write_reg == id_rs) |
                            (stage_q.write_reg == id_rt));

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (load_use_hazard) begin
      stage_d = '0;
    end else begin
      stage_d = id_stage;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // EX/MEM is the younger producer, so it is checked before MEM/WB.
  // r0 is hard-wired and is never forwarded.
  always_comb begin
    fwd_rs = stage_q.rd1;
    if (exmem_reg_write && (exmem_write_reg == stage_q.rs) && (stage_q.rs != '0)) begin
      fwd_rs = exmem_alu_result;
    end else if (memwb_reg_write && (memwb_write_reg == stage_q.rs) && (stage_q.rs != '0)) begin
      fwd_rs = memwb_write_data;
    end
  end

  always_comb begin
    fwd_rt = stage_q.rd2;
    if (exmem_reg_write && (exmem_write_reg == stage_q.rt) && (stage_q.rt != '0)) begin
      fwd_rt = exmem_alu_result;
    end else if (memwb_reg_write && (memwb_write_reg == stage_q.rt) && (stage_q.rt != '0)) begin
      fwd_rt = memwb_write_data;
    end
  end

  // For SLL, A carries the shift amount and B carries the value to shift.
  assign ex_a          = stage_q.shift ? {{(WIDTH-5){1'b0}}, stage_q.shamt} : fwd_rs;
  assign ex_b          = stage_q.alu_src ? stage_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;

  assign ex_valid         = stage_q.valid;
  assign ex_reg_write     = stage_q.reg_write;
  assign ex_mem_read      = stage_q.mem_read;
  assign ex_mem_write     = stage_q.mem_write;
  assign ex_mem_to_reg    = stage_q.mem_to_reg;
  assign ex_alu_operation = stage_q.alu_op;
  assign ex_write_reg     = stage_q.write_reg;

endmodule
